// File: rtl/rc4_phase_sequencer_if.sv
// Phase start/finish handshakes and the per-phase s_memory requests plus the muxed memory port.
// master = sequencer side; slave = phase FSMs / memory side.
interface rc4_phase_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              start_init;
    logic              start_shuffle;
    logic              start_decrypt;
    logic              finish_init;
    logic              finish_shuffle;
    logic              finish_decrypt;
    logic [ADDR_W-1:0] addr_init;
    logic [ADDR_W-1:0] addr_shuf;
    logic [ADDR_W-1:0] addr_dec;
    logic [DATA_W-1:0] data_init;
    logic [DATA_W-1:0] data_shuf;
    logic [DATA_W-1:0] data_dec;
    logic              wren_init;
    logic              wren_shuf;
    logic              wren_dec;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;

    modport master (
        output start_init, start_shuffle, start_decrypt,
        input  finish_init, finish_shuffle, finish_decrypt,
        input  addr_init, addr_shuf, addr_dec,
        input  data_init, data_shuf, data_dec,
        input  wren_init, wren_shuf, wren_dec,
        output mem_address, mem_data, mem_wren
    );

    modport slave (
        input  start_init, start_shuffle, start_decrypt,
        output finish_init, finish_shuffle, finish_decrypt,
        output addr_init, addr_shuf, addr_dec,
        output data_init, data_shuf, data_dec,
        output wren_init, wren_shuf, wren_dec,
        input  mem_address, mem_data, mem_wren
    );
endinterface

// File: rtl/rc4_phase_sequencer.sv
// Sequences RC4 init -> shuffle -> decrypt and owns the shared s_memory write port; status/start outputs are
// registered (1 cycle after the deciding edge), memory mux is combinational; no backpressure, phases hold via finish_*.
module rc4_phase_sequencer #(
    parameter int KEY_W          = 24,
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [KEY_W-1:0]       key_in,
    output logic [KEY_W-1:0]       key_out,
    rc4_phase_sequencer_if.master  bus,
    output logic [1:0]             phase,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [1:0]             err_phase
);
    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_INIT_GO, S_INIT_WAIT, S_SHUF_GO, S_SHUF_WAIT,
        S_DEC_GO, S_DEC_WAIT, S_DONE, S_ERROR
    } state_t;

    state_t            state, state_nxt;
    logic [WD_W-1:0]   wd, wd_nxt;
    logic [KEY_W-1:0]  key_nxt;
    logic [1:0]        err_nxt;
    logic              expired;

    function automatic logic [1:0] phase_of(input state_t s);
        case (s)
            S_INIT_GO, S_INIT_WAIT: phase_of = 2'd1;
            S_SHUF_GO, S_SHUF_WAIT: phase_of = 2'd2;
            S_DEC_GO,  S_DEC_WAIT:  phase_of = 2'd3;
            default:                phase_of = 2'd0;
        endcase
    endfunction

    assign expired = (wd == WD_MAX);

    always_comb begin
        state_nxt = state;
        wd_nxt    = wd;
        key_nxt   = key_out;
        err_nxt   = err_phase;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_nxt = S_INIT_GO;
                    key_nxt   = key_in;
                    err_nxt   = 2'd0;
                end
            end
            S_INIT_GO: begin state_nxt = S_INIT_WAIT; wd_nxt = '0; end
            S_SHUF_GO: begin state_nxt = S_SHUF_WAIT; wd_nxt = '0; end
            S_DEC_GO:  begin state_nxt = S_DEC_WAIT;  wd_nxt = '0; end
            // In each WAIT a finish on the expiry cycle still advances the run.
            S_INIT_WAIT: begin
                if (bus.finish_init)  state_nxt = S_SHUF_GO;
                else if (expired)     begin state_nxt = S_ERROR; err_nxt = 2'd1; end
                else                  wd_nxt = wd + 1'b1;
            end
            S_SHUF_WAIT: begin
                if (bus.finish_shuffle) state_nxt = S_DEC_GO;
                else if (expired)       begin state_nxt = S_ERROR; err_nxt = 2'd2; end
                else                    wd_nxt = wd + 1'b1;
            end
            S_DEC_WAIT: begin
                if (bus.finish_decrypt) state_nxt = S_DONE;
                else if (expired)       begin state_nxt = S_ERROR; err_nxt = 2'd3; end
                else                    wd_nxt = wd + 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (abort) begin
            state_nxt = S_IDLE;
            key_nxt   = key_out;
            err_nxt   = err_phase;
        end
    end

    // Status flops decode the next state so they line up with the state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= S_IDLE;
            wd                <= '0;
            key_out           <= '0;
            err_phase         <= 2'd0;
            phase             <= 2'd0;
            busy              <= 1'b0;
            done              <= 1'b0;
            error             <= 1'b0;
            bus.start_init    <= 1'b0;
            bus.start_shuffle <= 1'b0;
            bus.start_decrypt <= 1'b0;
        end else begin
            state             <= state_nxt;
            wd                <= wd_nxt;
            key_out           <= key_nxt;
            err_phase         <= err_nxt;
            phase             <= phase_of(state_nxt);
            busy              <= (phase_of(state_nxt) != 2'd0);
            done              <= (state_nxt == S_DONE);
            error             <= (state_nxt == S_ERROR);
            bus.start_init    <= (state_nxt == S_INIT_GO);
            bus.start_shuffle <= (state_nxt == S_SHUF_GO);
            bus.start_decrypt <= (state_nxt == S_DEC_GO);
        end
    end

    always_comb begin
        bus.mem_address = '0;
        bus.mem_data    = '0;
        bus.mem_wren    = 1'b0;
        case (phase)
            2'd1: begin bus.mem_address = bus.addr_init; bus.mem_data = bus.data_init; bus.mem_wren = bus.wren_init; end
            2'd2: begin bus.mem_address = bus.addr_shuf; bus.mem_data = bus.data_shuf; bus.mem_wren = bus.wren_shuf; end
            2'd3: begin bus.mem_address = bus.addr_dec;  bus.mem_data = bus.data_dec;  bus.mem_wren = bus.wren_dec;  end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_rc4_phase_sequencer.sv
// Directed bench for rc4_phase_sequencer with a shortened watchdog (1024 cycles).
module tb_rc4_phase_sequencer;
    localparam int TO = 1024;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [23:0] key_in = '0;
    logic [23:0] key_out;
    logic [1:0]  phase, err_phase;
    logic        busy, done, error;

    int errors = 0;
    int checks = 0;
    int n_si = 0, n_ss = 0, n_sd = 0;
    int ph_log[$];
    logic [1:0] last_ph = 2'd0;

    rc4_phase_sequencer_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    rc4_phase_sequencer #(.KEY_W(24), .ADDR_W(8), .DATA_W(8), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .key_in(key_in), .key_out(key_out), .bus(bus),
        .phase(phase), .busy(busy), .done(done), .error(error), .err_phase(err_phase)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.start_init)    n_si++;
        if (bus.start_shuffle) n_ss++;
        if (bus.start_decrypt) n_sd++;
        if (phase != last_ph) begin
            if (phase != 2'd0) ph_log.push_back(int'(phase));
            last_ph = phase;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_finish(input int which, input logic v);
        case (which)
            1: bus.finish_init    = v;
            2: bus.finish_shuffle = v;
            default: bus.finish_decrypt = v;
        endcase
    endtask

    // From X_GO: enter WAIT, hold n idle WAIT cycles, then finish on the next one.
    task automatic run_wait(input int which, input int n);
        tick;
        repeat (n) tick;
        set_finish(which, 1'b1);
        tick;
        set_finish(which, 1'b0);
    endtask

    task automatic kick(input logic [23:0] k);
        key_in = k;
        start  = 1'b1;
        tick;
        start  = 1'b0;
    endtask

    task automatic test_reset;
        #1 reset_n = 1'b0;
        #3;
        checks++;
        if ({phase, busy, done, error, err_phase, key_out} !== 31'd0) begin
            errors++;
            $display("FAIL reset_status: got ph=%0d busy=%b done=%b err=%b ep=%0d key=%h want all 0",
                     phase, busy, done, error, err_phase, key_out);
        end
        checks++;
        if ({bus.start_init, bus.start_shuffle, bus.start_decrypt, bus.mem_wren, bus.mem_address, bus.mem_data} !== 20'd0) begin
            errors++;
            $display("FAIL reset_bus: got starts=%b%b%b wren=%b addr=%h data=%h want 0",
                     bus.start_init, bus.start_shuffle, bus.start_decrypt, bus.mem_wren, bus.mem_address, bus.mem_data);
        end
        @(negedge clk) reset_n = 1'b1;
        tick;
        checks++;
        if ({phase, busy, done, error} !== 5'd0) begin
            errors++;
            $display("FAIL idle_after_reset: got ph=%0d busy=%b done=%b err=%b want 0", phase, busy, done, error);
        end
    endtask

    task automatic test_full_run;
        int bi, bs, bd, base;
        bi = n_si; bs = n_ss; bd = n_sd; base = ph_log.size();
        kick(24'h000249);
        checks++;
        if ({phase, busy, bus.start_init} !== {2'd1, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL init_go: got ph=%0d busy=%b si=%b want 1 1 1", phase, busy, bus.start_init);
        end
        run_wait(1, 255);
        checks++;
        if ({phase, bus.start_shuffle} !== {2'd2, 1'b1}) begin
            errors++;
            $display("FAIL shuf_go: got ph=%0d ss=%b want 2 1", phase, bus.start_shuffle);
        end
        run_wait(2, 767);
        run_wait(3, 31);
        checks++;
        if ({done, busy, error, phase} !== {1'b1, 1'b0, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL run_done: got done=%b busy=%b err=%b ph=%0d want 1 0 0 0", done, busy, error, phase);
        end
        checks++;
        if (key_out !== 24'h000249) begin
            errors++;
            $display("FAIL run_key: got %h want 000249", key_out);
        end
        checks++;
        if ((n_si - bi) != 1 || (n_ss - bs) != 1 || (n_sd - bd) != 1) begin
            errors++;
            $display("FAIL run_pulses: got %0d %0d %0d want 1 1 1", n_si - bi, n_ss - bs, n_sd - bd);
        end
        checks++;
        if (ph_log.size() != base + 3 || ph_log[base] != 1 || ph_log[base+1] != 2 || ph_log[base+2] != 3) begin
            errors++;
            $display("FAIL run_phase_order: got %0d entries want 1,2,3", ph_log.size() - base);
        end
    endtask

    task automatic test_mux_isolation;
        bus.addr_init = 8'h11; bus.addr_shuf = 8'h22; bus.addr_dec = 8'h33;
        bus.data_init = 8'hA1; bus.data_shuf = 8'hB2; bus.data_dec = 8'hC3;
        bus.wren_init = 1'b1;  bus.wren_shuf = 1'b1;  bus.wren_dec = 1'b1;
        #1;
        checks++;
        if ({bus.mem_wren, bus.mem_address, bus.mem_data} !== 17'd0) begin
            errors++;
            $display("FAIL mux_done_idle: got wren=%b addr=%h data=%h want 0 00 00", bus.mem_wren, bus.mem_address, bus.mem_data);
        end
        kick(24'h000001);
        checks++;
        if ({bus.mem_wren, bus.mem_address, bus.mem_data} !== {1'b1, 8'h11, 8'hA1}) begin
            errors++;
            $display("FAIL mux_init: got wren=%b addr=%h data=%h want 1 11 a1", bus.mem_wren, bus.mem_address, bus.mem_data);
        end
        run_wait(1, 2);
        tick;
        checks++;
        if ({bus.mem_wren, bus.mem_address, bus.mem_data} !== {1'b1, 8'h22, 8'hB2}) begin
            errors++;
            $display("FAIL mux_shuf: got wren=%b addr=%h data=%h want 1 22 b2", bus.mem_wren, bus.mem_address, bus.mem_data);
        end
        run_wait(2, 1);
        checks++;
        if ({bus.mem_wren, bus.mem_address, bus.mem_data} !== {1'b1, 8'h33, 8'hC3}) begin
            errors++;
            $display("FAIL mux_dec: got wren=%b addr=%h data=%h want 1 33 c3", bus.mem_wren, bus.mem_address, bus.mem_data);
        end
        run_wait(3, 2);
        checks++;
        if ({done, bus.mem_wren, bus.mem_address} !== {1'b1, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL mux_done: got done=%b wren=%b addr=%h want 1 0 00", done, bus.mem_wren, bus.mem_address);
        end
    endtask

    task automatic test_timeout_race;
        bus.finish_decrypt = 1'b1;
        kick(24'h123456);
        run_wait(1, TO - 1);
        checks++;
        if ({phase, bus.start_shuffle, error} !== {2'd2, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL race_finish_wins: got ph=%0d ss=%b err=%b want 2 1 0", phase, bus.start_shuffle, error);
        end
        tick;
        repeat (TO - 1) tick;
        checks++;
        if ({phase, error, busy} !== {2'd2, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL timeout_early: got ph=%0d err=%b busy=%b want 2 0 1", phase, error, busy);
        end
        tick;
        checks++;
        if ({error, err_phase, busy, phase, done, bus.mem_wren} !== {1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL timeout_error: got err=%b ep=%0d busy=%b ph=%0d done=%b wren=%b want 1 2 0 0 0 0",
                     error, err_phase, busy, phase, done, bus.mem_wren);
        end
        bus.finish_decrypt = 1'b0;
        kick(24'h654321);
        checks++;
        if ({error, err_phase, phase, busy, key_out} !== {1'b0, 2'd0, 2'd1, 1'b1, 24'h654321}) begin
            errors++;
            $display("FAIL restart_after_error: got err=%b ep=%0d ph=%0d busy=%b key=%h want 0 0 1 1 654321",
                     error, err_phase, phase, busy, key_out);
        end
        abort = 1'b1;
        tick;
        abort = 1'b0;
    endtask

    task automatic test_abort_ignore;
        kick(24'hA5A5A5);
        run_wait(1, 2);
        tick;
        key_in = 24'h5A5A5A;
        start  = 1'b1;
        tick;
        start  = 1'b0;
        checks++;
        if ({key_out, phase, busy, bus.start_init} !== {24'hA5A5A5, 2'd2, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL start_ignored: got key=%h ph=%0d busy=%b si=%b want a5a5a5 2 1 0",
                     key_out, phase, busy, bus.start_init);
        end
        abort = 1'b1;
        tick;
        abort = 1'b0;
        checks++;
        if ({phase, busy, done, error} !== 5'd0) begin
            errors++;
            $display("FAIL abort_shuf: got ph=%0d busy=%b done=%b err=%b want 0", phase, busy, done, error);
        end
        abort = 1'b1; start = 1'b1; key_in = 24'h0F0F0F;
        tick;
        abort = 1'b0; start = 1'b0;
        tick;
        checks++;
        if ({phase, busy, bus.start_init, key_out} !== {2'd0, 1'b0, 1'b0, 24'hA5A5A5}) begin
            errors++;
            $display("FAIL abort_beats_start: got ph=%0d busy=%b si=%b key=%h want 0 0 0 a5a5a5",
                     phase, busy, bus.start_init, key_out);
        end
    endtask

    task automatic test_reset_mid_run;
        kick(24'h0000AB);
        run_wait(1, 1);
        run_wait(2, 1);
        tick;
        checks++;
        if ({phase, busy} !== {2'd3, 1'b1}) begin
            errors++;
            $display("FAIL dec_wait_reached: got ph=%0d busy=%b want 3 1", phase, busy);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({phase, busy, done, error, err_phase, bus.mem_wren, bus.mem_address, key_out} !== 40'd0) begin
            errors++;
            $display("FAIL async_reset: got ph=%0d busy=%b wren=%b addr=%h key=%h want 0",
                     phase, busy, bus.mem_wren, bus.mem_address, key_out);
        end
        @(negedge clk) reset_n = 1'b1;
        tick;
        kick(24'h00BEEF);
        run_wait(1, 1);
        run_wait(2, 1);
        run_wait(3, 1);
        checks++;
        if ({done, busy, error, key_out} !== {1'b1, 1'b0, 1'b0, 24'h00BEEF}) begin
            errors++;
            $display("FAIL run_after_reset: got done=%b busy=%b err=%b key=%h want 1 0 0 00beef",
                     done, busy, error, key_out);
        end
    endtask

    initial begin
        bus.finish_init = 1'b0; bus.finish_shuffle = 1'b0; bus.finish_decrypt = 1'b0;
        bus.addr_init = '0; bus.addr_shuf = '0; bus.addr_dec = '0;
        bus.data_init = '0; bus.data_shuf = '0; bus.data_dec = '0;
        bus.wren_init = 1'b0; bus.wren_shuf = 1'b0; bus.wren_dec = 1'b0;
        test_reset;
        test_full_run;
        test_mux_isolation;
        test_timeout_race;
        test_abort_ignore;
        test_reset_mid_run;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
